ram_wait: RTL and testbench

//   Word-addressed on-chip RAM slave for the mem_valid/mem_ready bus, successor to the

---
 rtl/ram_wait.sv | 148 ++++++++++++++
 tb/tb_ram_wait.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/ram_wait.sv
// Word-addressed RAM slave for the mem_valid/mem_ready bus with LATENCY edges of access
// latency, base-address decode and an out-of-range error response.
module ram_wait #(
   parameter int          DEPTH     = 8,
   parameter int          LATENCY   = 1,
   parameter logic [31:0] BASE_ADDR = 32'h0
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        mem_valid,
   output logic        mem_ready,
   input  logic [31:0] mem_addr,
   output logic [31:0] mem_rdata,
   input  logic [31:0] mem_wdata,
   input  logic [3:0]  mem_wstrb,
   output logic        mem_err
);

   localparam int          WORDS    = 1 << DEPTH;
   localparam logic [32:0] SPAN     = 33'd4 << DEPTH;
   localparam logic [32:0] BASE_EXT = {1'b0, BASE_ADDR};
   localparam logic [3:0]  CNT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

   if (LATENCY < 1 || LATENCY > 16) begin : g_bad_latency
      $fatal(1, "ram_wait: LATENCY must be in 1..16");
   end
   if (DEPTH < 1 || DEPTH > 30 || (BASE_EXT & (SPAN - 33'd1)) != 33'd0) begin : g_bad_base
      $fatal(1, "ram_wait: BASE_ADDR must be aligned to 4*WORDS");
   end

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_next_state;
   logic [3:0]        r_cnt;
   logic [3:0]        w_cnt_next;
   logic              w_capture;
   logic              w_access;

   logic [DEPTH-1:0]  r_idx;
   logic [31:0]       r_wdata;
   logic [3:0]        r_wstrb;
   logic              r_in_range;
   logic [31:0]       r_rdata;
   logic              r_err;

   logic              w_in_range;
   logic [DEPTH-1:0]  w_acc_idx;
   logic [31:0]       w_acc_wdata;
   logic [3:0]        w_acc_wstrb;
   logic              w_acc_in_range;
   logic              w_we;

   logic [31:0]       r_mem [WORDS] = '{default: 32'h0};

   assign w_in_range = ({1'b0, mem_addr} >= BASE_EXT) &&
                       ({1'b0, mem_addr} <  BASE_EXT + SPAN);

   // The IDLE-state access (LATENCY=1) uses the live bus; later accesses use captured fields.
   assign w_acc_idx      = (r_state == S_IDLE) ? mem_addr[DEPTH+1:2] : r_idx;
   assign w_acc_wdata    = (r_state == S_IDLE) ? mem_wdata           : r_wdata;
   assign w_acc_wstrb    = (r_state == S_IDLE) ? mem_wstrb           : r_wstrb;
   assign w_acc_in_range = (r_state == S_IDLE) ? w_in_range          : r_in_range;
   assign w_we           = resetn && w_access && w_acc_in_range;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      w_next_state = r_state;
      w_cnt_next   = r_cnt;
      w_capture    = 1'b0;
      w_access     = 1'b0;
      mem_ready    = 1'b0;
      mem_err      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (mem_valid) begin
               w_capture = 1'b1;
               if (LATENCY == 1) begin
                  w_access     = 1'b1;
                  w_next_state = S_RESP;
               end else begin
                  w_cnt_next   = CNT_INIT;
                  w_next_state = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (r_cnt == 4'd0) begin
               w_access     = 1'b1;
               w_next_state = S_RESP;
            end else begin
               w_cnt_next = r_cnt - 4'd1;
            end
         end
         S_RESP: begin
            mem_ready    = 1'b1;
            mem_err      = r_err;
            w_next_state = S_IDLE;
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_state    <= S_IDLE;
         r_cnt      <= 4'd0;
         r_idx      <= '0;
         r_wdata    <= 32'h0;
         r_wstrb    <= 4'h0;
         r_in_range <= 1'b0;
         r_rdata    <= 32'h0;
         r_err      <= 1'b0;
      end else begin
         r_state <= w_next_state;
         r_cnt   <= w_cnt_next;
         if (w_capture) begin
            r_idx      <= mem_addr[DEPTH+1:2];
            r_wdata    <= mem_wdata;
            r_wstrb    <= mem_wstrb;
            r_in_range <= w_in_range;
         end
         if (w_access) begin
            r_rdata <= w_acc_in_range ? r_mem[w_acc_idx] : 32'h0;
            r_err   <= !w_acc_in_range;
         end
      end
   end

   // NOTE: the array has no reset branch so it maps onto block RAM; w_we already blocks writes under reset.
   always_ff @(posedge clk) begin
      if (w_we) begin
         for (int b = 0; b < 4; b++) begin
            if (w_acc_wstrb[b]) begin
               r_mem[w_acc_idx][8*b +: 8] <= w_acc_wdata[8*b +: 8];
            end
         end
      end
   end

   assign mem_rdata = r_rdata;

endmodule

// File: tb/tb_ram_wait.sv
// Bench for ram_wait: three instances (LATENCY 1/4/3, one with BASE_ADDR 0x1000) driven
// by directed steps, with expected responses queued at issue and checked at mem_ready.
module tb_ram_wait;

   localparam int N_DUT = 3;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          dut;
   } exp_t;

   logic              clk;
   logic              resetn;
   logic [N_DUT-1:0]  valid;
   logic [31:0]       addr;
   logic [31:0]       wdata;
   logic [3:0]        wstrb;
   logic [N_DUT-1:0]  ready;
   logic [N_DUT-1:0]  err;
   logic [31:0]       rdata [N_DUT];

   int                lat_of  [N_DUT] = '{1, 4, 3};
   longint            base_of [N_DUT] = '{64'h0, 64'h1000, 64'h0};
   logic [31:0]       mdl [N_DUT][256];
   exp_t              sb_q [$];
   int                n_vec = 0;
   int                n_err = 0;

   ram_wait #(.DEPTH(8), .LATENCY(1), .BASE_ADDR(32'h0)) u_dut0 (
      .clk(clk), .resetn(resetn), .mem_valid(valid[0]), .mem_ready(ready[0]),
      .mem_addr(addr), .mem_rdata(rdata[0]), .mem_wdata(wdata), .mem_wstrb(wstrb),
      .mem_err(err[0]));

   ram_wait #(.DEPTH(8), .LATENCY(4), .BASE_ADDR(32'h1000)) u_dut1 (
      .clk(clk), .resetn(resetn), .mem_valid(valid[1]), .mem_ready(ready[1]),
      .mem_addr(addr), .mem_rdata(rdata[1]), .mem_wdata(wdata), .mem_wstrb(wstrb),
      .mem_err(err[1]));

   ram_wait #(.DEPTH(8), .LATENCY(3), .BASE_ADDR(32'h0)) u_dut2 (
      .clk(clk), .resetn(resetn), .mem_valid(valid[2]), .mem_ready(ready[2]),
      .mem_addr(addr), .mem_rdata(rdata[2]), .mem_wdata(wdata), .mem_wstrb(wstrb),
      .mem_err(err[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_vec++;
      assert (obs === exp_v) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
      end
   endtask

   // One bus transaction; drop releases valid and scrambles the bus right after the
   // sample edge, keep holds valid across the RESP->IDLE edge.
   task automatic issue(input int d, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] ws, input bit drop, input bit keep);
      exp_t        e;
      exp_t        got;
      logic [31:0] w;
      logic [7:0]  idx;
      int          edges;
      idx = a[9:2];
      e.dut = d;
      if (longint'(a) >= base_of[d] && longint'(a) < base_of[d] + 1024) begin
         w = mdl[d][idx];
         e.rdata = w;
         e.err   = 1'b0;
         for (int b = 0; b < 4; b++) begin
            if (ws[b]) w[8*b +: 8] = wd[8*b +: 8];
         end
         mdl[d][idx] = w;
      end else begin
         e.rdata = 32'h0;
         e.err   = 1'b1;
      end
      sb_q.push_back(e);

      @(negedge clk);
      addr = a; wdata = wd; wstrb = ws; valid[d] = 1'b1;
      @(posedge clk); #1;
      if (drop) begin
         valid[d] = 1'b0;
         addr  = a ^ 32'h4;
         wdata = ~wd;
         wstrb = 4'hF;
      end
      edges = 0;
      while (ready[d] !== 1'b1 && edges < 40) begin
         @(posedge clk); #1;
         edges++;
      end
      check($sformatf("latency d%0d @%h", d, a), 32'(edges), 32'(lat_of[d] - 1));
      got = sb_q.pop_front();
      check($sformatf("rdata d%0d @%h", d, a), rdata[got.dut], got.rdata);
      check($sformatf("err d%0d @%h", d, a), 32'(err[got.dut]), 32'(got.err));
      if (!keep) valid[d] = 1'b0;
      @(posedge clk); #1;
      check($sformatf("ready pulse d%0d @%h", d, a), 32'(ready[d]), 32'h0);
      check($sformatf("err idle d%0d @%h", d, a), 32'(err[d]), 32'h0);
   endtask

   // Write that is cut by reset at edge E0+rst_edge; no response and no write may follow.
   task automatic abort_write(input int d, input logic [31:0] a, input logic [31:0] wd,
                              input int rst_edge);
      @(negedge clk);
      addr = a; wdata = wd; wstrb = 4'hF; valid[d] = 1'b1;
      @(posedge clk);
      repeat (rst_edge - 1) @(posedge clk);
      @(negedge clk);
      resetn = 1'b0; valid[d] = 1'b0;
      @(posedge clk); #1;
      check($sformatf("abort ready d%0d E%0d", d, rst_edge), 32'(ready[d]), 32'h0);
      check($sformatf("abort rdata d%0d E%0d", d, rst_edge), rdata[d], 32'h0);
      @(negedge clk);
      resetn = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1;
         check($sformatf("abort no ready d%0d E%0d +%0d", d, rst_edge, k), 32'(ready[d]), 32'h0);
      end
   endtask

   initial begin
      for (int d = 0; d < N_DUT; d++) begin
         for (int i = 0; i < 256; i++) mdl[d][i] = 32'h0;
      end

      // Reset held for two edges with a live write request on every instance.
      resetn = 1'b0; valid = '1;
      addr = 32'h10; wdata = 32'hFFFF_FFFF; wstrb = 4'hF;
      repeat (2) @(posedge clk);
      #1;
      for (int d = 0; d < N_DUT; d++) begin
         check($sformatf("reset ready d%0d", d), 32'(ready[d]), 32'h0);
         check($sformatf("reset rdata d%0d", d), rdata[d], 32'h0);
         check($sformatf("reset err d%0d", d), 32'(err[d]), 32'h0);
      end
      @(negedge clk);
      valid = '0; resetn = 1'b1;

      // LATENCY=1 write then read; the write returns the old (zero) word.
      issue(0, 32'h10, 32'hDEAD_BEEF, 4'hF, 1'b0, 1'b0);
      issue(0, 32'h10, 32'h0,         4'h0, 1'b0, 1'b0);

      // Byte lanes.
      issue(0, 32'h20, 32'h1122_3344, 4'hF, 1'b0, 1'b0);
      issue(0, 32'h20, 32'hAABB_CCDD, 4'h5, 1'b0, 1'b0);
      issue(0, 32'h20, 32'h0,         4'h0, 1'b0, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      check("rdata hold d0", rdata[0], 32'h11BB_33DD);

      // LATENCY=4: back-to-back with valid held, then captured fields with valid dropped.
      issue(1, 32'h1040, 32'hA5A5_0001, 4'hF, 1'b0, 1'b0);
      issue(1, 32'h1044, 32'h5A5A_0002, 4'hF, 1'b0, 1'b1);
      issue(1, 32'h1040, 32'h0,         4'h0, 1'b1, 1'b0);
      issue(1, 32'h1044, 32'h0,         4'h0, 1'b0, 1'b0);

      // Range decode around BASE_ADDR=0x1000, 256 words.
      issue(1, 32'h0FFC, 32'h1111_1111, 4'hF, 1'b0, 1'b0);
      issue(1, 32'h1400, 32'h2222_2222, 4'hF, 1'b0, 1'b0);
      issue(1, 32'h1000, 32'h0,         4'h0, 1'b0, 1'b0);
      issue(1, 32'h13FC, 32'h3333_3333, 4'hF, 1'b0, 1'b0);
      issue(1, 32'h13FC, 32'h0,         4'h0, 1'b0, 1'b0);

      // LATENCY=3: reset during a write at E1 and at the access edge E2.
      issue(2, 32'h30, 32'h1234_5678, 4'hF, 1'b0, 1'b0);
      abort_write(2, 32'h30, 32'hCAFE_F00D, 1);
      abort_write(2, 32'h30, 32'h0BAD_F00D, 2);
      issue(2, 32'h30, 32'h0, 4'h0, 1'b0, 1'b0);

      check("scoreboard drained", 32'(sb_q.size()), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
